// File: rtl/beam_ctrl_pkg.sv
// Shared constants and types for the beamformer threshold control path.
package beam_ctrl_pkg;

  localparam int unsigned THRESH_BITS = 18;
  localparam logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'h3FFFF;

  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_LOAD   = 2'd1,
    LDR_UPDATE = 2'd2
  } loader_state_e;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/beam_thresh_table.sv
// Per-beam threshold registers with dirty flags: one write port, one scan read port.
module beam_thresh_table
  import beam_ctrl_pkg::*;
#(
  parameter int unsigned NBEAMS = 48,
  parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = beam_ctrl_pkg::DEFAULT_THRESH,
  parameter int unsigned IDX_BITS = idx_bits(NBEAMS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en,
  input  logic [IDX_BITS-1:0]    wr_idx,
  input  logic [THRESH_BITS-1:0] wr_data,
  input  logic [IDX_BITS-1:0]    rd_idx,
  input  logic                   clr_en,
  output logic [THRESH_BITS-1:0] rd_data,
  output logic                   rd_dirty
);

  logic [THRESH_BITS-1:0] thr_q [NBEAMS];
  logic [NBEAMS-1:0]      dirty_q;
  logic                   wr_in_range;
  logic                   rd_in_range;

  assign wr_in_range = 32'(wr_idx) < NBEAMS;
  assign rd_in_range = 32'(rd_idx) < NBEAMS;

  // A write in the same cycle as a clear of the same entry keeps it dirty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NBEAMS); i++) begin
        thr_q[i] <= DEFAULT_THRESH;
      end
      dirty_q <= '1;
    end else begin
      if (clr_en && rd_in_range) begin
        dirty_q[rd_idx] <= 1'b0;
      end
      if (wr_en && wr_in_range) begin
        thr_q[wr_idx]   <= wr_data;
        dirty_q[wr_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_dirty = 1'b0;
    if (rd_in_range) begin
      rd_data  = thr_q[rd_idx];
      rd_dirty = dirty_q[rd_idx];
    end
  end

endmodule

// File: rtl/beam_thresh_loader.sv
// Stages per-beam thresholds and, on commit, streams dirty entries to the beamformers then strobes update.
module beam_thresh_loader
  import beam_ctrl_pkg::*;
#(
  parameter int unsigned NBEAMS = 48,
  parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = beam_ctrl_pkg::DEFAULT_THRESH,
  localparam int unsigned IDX_BITS = idx_bits(NBEAMS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [IDX_BITS-1:0]    wr_beam_i,
  input  logic [THRESH_BITS-1:0] wr_thresh_i,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic                   bad_index_o,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o
);

  localparam logic [1:0] ST_IDLE   = 2'(LDR_IDLE);
  localparam logic [1:0] ST_LOAD   = 2'(LDR_LOAD);
  localparam logic [1:0] ST_UPDATE = 2'(LDR_UPDATE);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NBEAMS - 1);

  logic [1:0]             state_q, state_n;
  logic [IDX_BITS-1:0]    idx_q, idx_n;
  logic                   pend_q, pend_n;
  logic [THRESH_BITS-1:0] thresh_q, thresh_n;
  logic [NBEAMS-1:0]      ce_q, ce_n;
  logic                   update_q, update_n;
  logic                   bad_q, bad_n;

  logic                   wr_accept;
  logic                   wr_in_range;
  logic                   clr_en;
  logic [THRESH_BITS-1:0] rd_data;
  logic                   rd_dirty;

  assign wr_ready_o  = (state_q == ST_IDLE) & ~rst_i;
  assign busy_o      = (state_q != ST_IDLE) | rst_i;
  assign wr_accept   = wr_valid_i & wr_ready_o;
  assign wr_in_range = 32'(wr_beam_i) < NBEAMS;

  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign update_o    = update_q;
  assign bad_index_o = bad_q;

  beam_thresh_table #(
    .NBEAMS        (NBEAMS),
    .DEFAULT_THRESH(DEFAULT_THRESH),
    .IDX_BITS      (IDX_BITS)
  ) u_table (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_accept & wr_in_range),
    .wr_idx  (wr_beam_i),
    .wr_data (wr_thresh_i),
    .rd_idx  (idx_q),
    .clr_en  (clr_en),
    .rd_data (rd_data),
    .rd_dirty(rd_dirty)
  );

  // Scan FSM: fixed-length walk over every beam, then a single apply strobe.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    pend_n   = pend_q;
    thresh_n = thresh_q;
    ce_n     = '0;
    update_n = 1'b0;
    clr_en   = 1'b0;
    bad_n    = wr_accept & ~wr_in_range;
    case (state_q)
      ST_IDLE: begin
        if (commit_i || pend_q) begin
          state_n = ST_LOAD;
          idx_n   = '0;
          pend_n  = 1'b0;
        end
      end
      ST_LOAD: begin
        thresh_n = rd_data;
        if (rd_dirty) begin
          ce_n = NBEAMS'(1) << idx_q;
        end
        clr_en = 1'b1;
        idx_n  = idx_q + IDX_BITS'(1);
        if (idx_q == LAST_IDX) begin
          state_n = ST_UPDATE;
        end
        if (commit_i) begin
          pend_n = 1'b1;
        end
      end
      ST_UPDATE: begin
        update_n = 1'b1;
        state_n  = ST_IDLE;
        if (commit_i) begin
          pend_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Reset lands in LOAD with every entry dirty so the defaults are pushed automatically.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      thresh_q <= '0;
      ce_q     <= '0;
      update_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      pend_q   <= pend_n;
      thresh_q <= thresh_n;
      ce_q     <= ce_n;
      update_q <= update_n;
      bad_q    <= bad_n;
    end
  end

endmodule
